// File: rtl/alu_mb.sv
// ---------------------------------------------------------------------------
// alu_mb -- multi-cycle byte-serial ALU.
//
// An operation is accepted in IDLE, then processed one byte slice per cycle
// in RUN (NB = WIDTH/8 cycles), and presented in DONE until consumed.
// A carry register runs between slices, seeded with ci. Shift-left and
// binary/decimal add walk the slices LSB-first; shift-right walks MSB-first.
//
// Op encoding (op):
//   0 ALU_ADD  1 ALU_AND  2 ALU_OR  3 ALU_XOR  4 ALU_BIT  5 ALU_SL  6 ALU_SR
//   7 undefined (result 0, Z=1, other flags 0)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (ready only in IDLE)
//   ai, bi, ci, dec, op  operands, carry in, BCD mode (ADD only), operation
//   out_valid/out_ready  result handshake (valid only in DONE)
//   out, N, V, Z, C      result and flags, held until the next result
// ---------------------------------------------------------------------------
module alu_mb #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic             ci,
    input  logic             dec,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             N,
    output logic             V,
    output logic             Z,
    output logic             C
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_BIT = 3'd4;
    localparam logic [2:0] ALU_SL  = 3'd5;
    localparam logic [2:0] ALU_SR  = 3'd6;

    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              dec_q;
    logic [2:0]        op_q;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
    logic              accept;

    // Slice datapath signals
    logic [CW-1:0]     idx;
    logic [CW+2:0]     sh;
    logic [7:0]        a_s, b_s, or_s, r_s;
    logic              cout, v_s;
    logic [4:0]        lo, hi;

    // One BCD digit add: returns {carry, digit}. A raw sum above 9 is
    // corrected by +6; wrapping in 4 bits gives the right digit for any
    // 5-bit sum, so non-BCD inputs still yield a defined value.
    function automatic logic [4:0] bcd_digit(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        if (s > 5'd9) return {1'b1, s[3:0] + 4'd6};
        else          return {1'b0, s[3:0]};
    endfunction

    // Slice selection and per-slice operation
    always_comb begin
        idx  = (op_q == ALU_SR) ? (CW'(NB - 1) - cnt_q) : cnt_q;
        sh   = {idx, 3'b000};
        a_s  = 8'(a_q >> sh);
        b_s  = 8'(b_q >> sh);
        or_s = a_s | b_s;
        r_s  = 8'h00;
        cout = 1'b0;
        v_s  = 1'b0;
        lo   = 5'd0;
        hi   = 5'd0;
        case (op_q)
            ALU_ADD: begin
                if (dec_q) begin
                    lo   = bcd_digit(a_s[3:0], b_s[3:0], carry_q);
                    hi   = bcd_digit(a_s[7:4], b_s[7:4], lo[4]);
                    r_s  = {hi[3:0], lo[3:0]};
                    cout = hi[4];
                end else begin
                    {cout, r_s} = {1'b0, a_s} + {1'b0, b_s} + {8'd0, carry_q};
                    // Only the last (MSB) slice's value reaches V.
                    v_s = (a_s[7] ^ r_s[7]) & (b_s[7] ^ r_s[7]);
                end
            end
            ALU_AND, ALU_BIT: r_s = a_s & b_s;
            ALU_OR:           r_s = a_s | b_s;
            ALU_XOR:          r_s = a_s ^ b_s;
            ALU_SL: begin
                r_s  = {or_s[6:0], carry_q};
                cout = or_s[7];
            end
            ALU_SR: begin
                r_s  = {carry_q, or_s[7:1]};
                cout = or_s[0];
            end
            default: ;
        endcase
    end

    // FSM next state, outputs and result capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        res_d     = res_q;
        out_d     = out_q;
        n_d       = n_q;
        v_d       = v_q;
        z_d       = z_q;
        c_d       = c_q;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                    res_d   = '0;
                    carry_d = ci;
                end
            end
            RUN: begin
                // res_q was cleared on accept and each slice is written once.
                res_d   = res_q | (WIDTH'(r_s) << sh);
                carry_d = cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NB - 1)) begin
                    state_d = DONE;
                    out_d   = res_d;
                    z_d     = (res_d == '0);
                    n_d     = (op_q == ALU_BIT) ? b_q[WIDTH-1] : res_d[WIDTH-1];
                    if (op_q == ALU_BIT)
                        v_d = b_q[WIDTH-2];
                    else if (op_q == ALU_ADD && !dec_q)
                        v_d = v_s;
                    else
                        v_d = 1'b0;
                    c_d = (op_q == ALU_ADD || op_q == ALU_SL || op_q == ALU_SR)
                          ? cout : 1'b0;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible-result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            n_q     <= n_d;
            v_q     <= v_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    // Operand latch and working registers
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= ai;
            b_q   <= bi;
            dec_q <= dec;
            op_q  <= op;
        end
        carry_q <= carry_d;
        res_q   <= res_d;
    end

    assign out = out_q;
    assign N   = n_q;
    assign V   = v_q;
    assign Z   = z_q;
    assign C   = c_q;

endmodule

// File: tb/tb_alu_mb.sv
// Bench for alu_mb at WIDTH=16: directed vector table, handshake/reset
// sequences and randomized operations against a behavioural model.
module tb_alu_mb;

    localparam int WIDTH = 16;
    localparam int NB    = WIDTH / 8;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_BIT = 3'd4;
    localparam logic [2:0] ALU_SL  = 3'd5;
    localparam logic [2:0] ALU_SR  = 3'd6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] ai = '0;
    logic [WIDTH-1:0] bi = '0;
    logic             ci = 1'b0;
    logic             dec = 1'b0;
    logic [2:0]       op = 3'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out;
    logic             N, V, Z, C;

    alu_mb #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ai(ai), .bi(bi), .ci(ci), .dec(dec), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .N(N), .V(V), .Z(Z), .C(C)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] out;
        logic        n, v, z, c;
    } res_t;

    typedef struct {
        string       name;
        logic [15:0] a, b;
        logic        ci, dec;
        logic [2:0]  op;
        logic [19:0] exp;   // {out, N, V, Z, C}
    } vec_t;

    function automatic logic [19:0] pk(input res_t r);
        return {r.out, r.n, r.v, r.z, r.c};
    endfunction

    function automatic logic [19:0] dut_pk();
        return {out, N, V, Z, C};
    endfunction

    // Behavioural reference: whole-word arithmetic, decimal add digit by digit.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic d,
                                   input logic [2:0] o);
        res_t        r;
        logic [16:0] s;
        int          carry, dig;
        r = '{out: 16'h0, n: 1'b0, v: 1'b0, z: 1'b0, c: 1'b0};
        case (o)
            ALU_ADD: begin
                if (d) begin
                    carry = int'(cin);
                    for (int k = 0; k < 4; k++) begin
                        dig = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + carry;
                        if (dig > 9) begin dig += 6; carry = 1; end
                        else carry = 0;
                        r.out[4*k +: 4] = 4'(dig % 16);
                    end
                    r.c = (carry != 0);
                end else begin
                    s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                    r.out = s[15:0];
                    r.c   = s[16];
                    r.v   = (a[15] ^ r.out[15]) & (b[15] ^ r.out[15]);
                end
            end
            ALU_AND: r.out = a & b;
            ALU_OR:  r.out = a | b;
            ALU_XOR: r.out = a ^ b;
            ALU_BIT: r.out = a & b;
            ALU_SL: begin
                r.out = ((a | b) << 1) | {15'd0, cin};
                r.c   = (a[15] | b[15]);
            end
            ALU_SR: begin
                r.out = ((a | b) >> 1) | {cin, 15'd0};
                r.c   = (a[0] | b[0]);
            end
            default: r.out = 16'h0;
        endcase
        r.z = (r.out == 16'h0);
        if (o == ALU_BIT) begin
            r.n = b[15];
            r.v = b[14];
        end else begin
            r.n = r.out[15];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble inputs after accept, wait for DONE,
    // return the presented result, then consume it.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic d, input logic [2:0] o,
                         output logic [19:0] got, output int lat);
        int          g;
        logic [15:0] prev;
        prev = out;
        g = 0;
        while (!in_ready && g < 20) begin @(posedge clk); #1; g++; end
        chk("ready_before_op", 32'(in_ready), 32'd1);
        ai = a; bi = b; ci = c; dec = d; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        in_valid = 1'b0;
        ai = 16'($urandom); bi = 16'($urandom); ci = 1'($urandom);
        dec = 1'($urandom); op = 3'($urandom);
        while (!out_valid && lat < 20) begin
            chk("hold_while_run", 32'(out), 32'(prev));
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        got = dut_pk();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after_consume", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    vec_t        vecs[$];
    logic [19:0] got, snap;
    int          lat, g;
    logic [15:0] ra, rb;
    logic [2:0]  ro;
    logic        rc, rd;

    initial begin
        vecs.push_back('{"add_bin",      16'h12FF, 16'h0001, 1'b0, 1'b0, ALU_ADD, {16'h1300, 4'b0000}});
        vecs.push_back('{"add_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, ALU_ADD, {16'h8000, 4'b1100}});
        vecs.push_back('{"add_carry",    16'hFFFF, 16'h0000, 1'b1, 1'b0, ALU_ADD, {16'h0000, 4'b0011}});
        vecs.push_back('{"add_neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, ALU_ADD, {16'h0000, 4'b0111}});
        vecs.push_back('{"dec_0999",     16'h0999, 16'h0001, 1'b0, 1'b1, ALU_ADD, {16'h1000, 4'b0000}});
        vecs.push_back('{"dec_9999",     16'h9999, 16'h0001, 1'b0, 1'b1, ALU_ADD, {16'h0000, 4'b0011}});
        vecs.push_back('{"dec_ci",       16'h0048, 16'h0051, 1'b1, 1'b1, ALU_ADD, {16'h0100, 4'b0000}});
        vecs.push_back('{"sr",           16'h0001, 16'h0000, 1'b1, 1'b0, ALU_SR,  {16'h8000, 4'b1001}});
        vecs.push_back('{"sl",           16'h8001, 16'h0000, 1'b0, 1'b0, ALU_SL,  {16'h0002, 4'b0001}});
        vecs.push_back('{"sl_bport",     16'h0000, 16'h4000, 1'b1, 1'b0, ALU_SL,  {16'h8001, 4'b1000}});
        vecs.push_back('{"bit",          16'h00FF, 16'hC000, 1'b0, 1'b0, ALU_BIT, {16'h0000, 4'b1110}});
        vecs.push_back('{"bit_v",        16'hFFFF, 16'h4001, 1'b1, 1'b0, ALU_BIT, {16'h4001, 4'b0100}});
        vecs.push_back('{"and_dec_ign",  16'hFFFF, 16'h1234, 1'b1, 1'b1, ALU_AND, {16'h1234, 4'b0000}});
        vecs.push_back('{"or",           16'hF0F0, 16'h0F0F, 1'b1, 1'b0, ALU_OR,  {16'hFFFF, 4'b1000}});
        vecs.push_back('{"xor_zero",     16'hAAAA, 16'hAAAA, 1'b1, 1'b0, ALU_XOR, {16'h0000, 4'b0010}});
        vecs.push_back('{"undef_op",     16'h1234, 16'h8765, 1'b1, 1'b0, 3'd7,    {16'h0000, 4'b0010}});

        // Reset state
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("reset_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
        chk("reset_outputs", 32'(dut_pk()), 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].dec, vecs[i].op, got, lat);
            chk(vecs[i].name, 32'(got), 32'(vecs[i].exp));
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(NB + 1));
        end

        // Result held in DONE while out_ready is low
        ai = 16'h7FFF; bi = 16'h0001; ci = 1'b0; dec = 1'b0; op = ALU_ADD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
        chk("done_reached", 32'(out_valid), 32'd1);
        snap = dut_pk();
        chk("done_value", 32'(snap), 32'(pk(model(16'h7FFF, 16'h0001, 1'b0, 1'b0, ALU_ADD))));
        for (int i = 0; i < 5; i++) begin
            ai = 16'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("done_hold_outputs", 32'(dut_pk()), 32'(snap));
            chk("done_hold_handshake", {30'd0, in_ready, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_keeps_result", 32'(dut_pk()), 32'(snap));

        // Reset during RUN discards the operation
        ai = 16'h1111; bi = 16'h2222; op = ALU_ADD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_run_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        chk("rst_run_outputs", 32'(dut_pk()), 32'd0);
        tick(4);
        chk("rst_run_no_result", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset in DONE, with a concurrent consume
        ai = 16'hFFFF; bi = 16'h0000; ci = 1'b1; op = ALU_ADD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tick(NB);
        chk("rst_done_reached", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        chk("rst_done_outputs", 32'(dut_pk()), 32'd0);
        chk("rst_done_handshake", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset overrides a concurrent accept
        ai = 16'h7FFF; bi = 16'h0001; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        tick(NB + 2);
        chk("rst_beats_accept", {30'd0, in_ready, out_valid}, 32'd2);
        chk("rst_beats_accept_out", 32'(dut_pk()), 32'd0);

        // Randomized operations against the model
        for (int t = 0; t < 300; t++) begin
            ro = 3'($urandom_range(0, 7));
            rd = 1'($urandom);
            rc = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (ro == ALU_ADD && rd) begin
                for (int k = 0; k < 4; k++) begin
                    ra[4*k +: 4] = 4'($urandom_range(0, 9));
                    rb[4*k +: 4] = 4'($urandom_range(0, 9));
                end
            end
            if ((ro == ALU_SL || ro == ALU_SR) && $urandom_range(0, 1) == 0)
                rb = 16'h0;
            do_op(ra, rb, rc, rd, ro, got, lat);
            chk("random_result", 32'(got), 32'(pk(model(ra, rb, rc, rd, ro))));
            chk("random_latency", 32'(lat), 32'(NB + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mb.md
ALU_MB -- requirements
Module: alu_mb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL derive NB = WIDTH/8, the number of byte slices; this is not a port-visible parameter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-007 SHALL have ports ai and bi, input, WIDTH each, operands.
REQ-008 SHALL have port ci, input, 1, carry in.
REQ-009 SHALL have port dec, input, 1, decimal (BCD) mode, honoured for ALU_ADD only.
REQ-010 SHALL have port op, input, 3, operation, encoded with the ALU_* constants in defs.vh.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-013 SHALL have port out, output, WIDTH, result.
REQ-014 SHALL have ports N, V, Z and C, output, 1 each, result flags.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE -> RUN on accept.
- RUN -> DONE after NB slice cycles.
- DONE -> IDLE on out_ready.
REQ-016 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-017 SHALL on accept latch ai, bi, ci, dec and op, and clear the slice counter and result register.
REQ-018 SHALL process exactly one byte slice per RUN cycle, so out_valid rises NB+1 cycles after the accepting cycle (3 cycles for WIDTH=16).
REQ-019 SHALL process slices LSB-first for ALU_ADD and ALU_SL, MSB-first for ALU_SR, and in either order for the bitwise ops (result-identical).
REQ-020 SHALL carry a running carry register between slices, seeded with ci; the carry out of the final slice is C.
REQ-021 SHALL for ALU_AND, ALU_OR and ALU_XOR produce the bitwise op on WIDTH bits, with C=0.
REQ-022 SHALL for ALU_BIT produce out = ai & bi, N = bi[WIDTH-1], V = bi[WIDTH-2] and C = 0.
REQ-023 SHALL for ALU_SL produce {C,out} = {ai|bi, ci}; the unused operand port is zero by caller contract.
REQ-024 SHALL for ALU_SR produce {out,C} = {ci, ai|bi}.
REQ-025 SHALL for binary ALU_ADD produce {C,out} = ai + bi + ci (WIDTH+1 bits).
REQ-026 SHALL for binary ALU_ADD set V = (ai[MSB]^out[MSB]) & (bi[MSB]^out[MSB]), evaluated on the MSB slice.
REQ-027 SHALL for decimal ALU_ADD treat each nibble as a BCD digit, per slice:
- low digit: sum = a + b + carry; if sum > 9 then add 6 and carry 1 into the high digit.
- high digit: same rule; its carry is the slice carry.
REQ-028 SHALL for decimal ALU_ADD set V = 0; results for non-BCD inputs are unspecified, but no X is produced.
REQ-029 SHALL set V = 0 for every op other than ALU_ADD and ALU_BIT.
REQ-030 SHALL set N = out[WIDTH-1] (except ALU_BIT) and Z = (out == 0), both from the final, corrected result.
REQ-031 SHALL treat undefined op encodings as out = 0, C = 0, V = 0, Z = 1, N = 0.
REQ-032 SHALL hold out, N, V, Z and C stable throughout DONE while out_ready is low.
REQ-033 SHALL keep out and all flags at their previous values in IDLE and RUN.
REQ-034 SHALL ignore input changes after the accepting cycle.

Reset
REQ-035 SHALL on rst go to IDLE and set in_ready = 1, out_valid = 0, out = 0 and N = V = Z = C = 0 on the next edge.
REQ-036 SHALL let rst override any concurrent accept or consume.
REQ-037 SHALL on rst asserted mid-RUN or in DONE discard the operation, with no partial result visible.

Verification (WIDTH=16)
REQ-038 SHALL cover binary ADD: 0x12FF + 0x0001, ci=0 -> out=0x1300, C=0, V=0, Z=0, N=0, with out_valid exactly 3 cycles after accept.
REQ-039 SHALL cover overflow: ADD 0x7FFF + 0x0001 -> out=0x8000, V=1, N=1, C=0; and ADD 0xFFFF + 0x0000, ci=1 -> 0x0000, C=1, Z=1.
REQ-040 SHALL cover decimal ADD:
- 0x0999 + 0x0001 -> 0x1000, C=0.
- 0x9999 + 0x0001 -> 0x0000, C=1, Z=1, V=0.
REQ-041 SHALL cover shifts:
- SR ai=0x0001, bi=0, ci=1 -> 0x8000, C=1, N=1.
- SL ai=0x8001, bi=0, ci=0 -> 0x0002, C=1.
REQ-042 SHALL cover BIT: ai=0x00FF, bi=0xC000 -> out=0x0000, Z=1, N=1, V=1, C=0.
REQ-043 SHALL cover handshake and reset:
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0.
- rst pulsed during RUN -> next cycle IDLE, out_valid=0, in_ready=1, all outputs 0.
